// File: rtl/timer_preset_writer_pkg.sv
// Shared types and digit helpers for the countdown-timer preset writer.
// FSM state encodings double as the edit_sel codes seen on the front panel.
package timer_pkg;

    typedef enum logic [1:0] {
        S_MIN    = 2'd0,
        S_TENS   = 2'd1,
        S_ONES   = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

    localparam logic [1:0] SEL_MIN    = 2'd0;
    localparam logic [1:0] SEL_TENS   = 2'd1;
    localparam logic [1:0] SEL_ONES   = 2'd2;
    localparam logic [1:0] SEL_COMMIT = 2'd3;

    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

    // Wrap-around BCD digit step; an out-of-range digit is pulled back into range.
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] max);
        return (d == 4'd0 || d > max) ? max : d - 4'd1;
    endfunction

    function automatic state_e next_edit(input state_e s);
        case (s)
            S_MIN:   return S_TENS;
            S_TENS:  return S_ONES;
            default: return S_MIN;
        endcase
    endfunction

endpackage

// File: rtl/timer_preset_writer_if.sv
// Preset load channel between the panel writer (master) and the countdown block (slave).
// The master holds load_valid and the digits stable until load_ready is seen on a clock edge.
interface timer_load_if;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_mins;
    logic [3:0] load_tens;
    logic [3:0] load_ones;

    modport master (output load_valid, load_mins, load_tens, load_ones, input load_ready);
    modport slave  (input load_valid, load_mins, load_tens, load_ones, output load_ready);
endinterface

// File: rtl/timer_preset_writer_key_debounce.sv
// Debouncer for one raw active-low pushbutton: stable level plus a one-cycle press pulse.
// Leaves reset in the released state so no press is reported on reset exit.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          raw_q;
    logic [CW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            raw_q <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (raw_n != raw_q) begin
                raw_q <= raw_n;
                cnt   <= '0;
            end else if (raw_q != level) begin
                if (cnt == LAST) begin
                    level <= raw_q;
                    cnt   <= '0;
                    press <= ~raw_q;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/timer_preset_writer.sv
// Front-panel preset writer: debounced keys edit a BCD M:SS preset, go hands it to the timer.
// Optional auto-repeat of held inc/dec keys is built when PRESET_AUTOREPEAT_EN is defined.
module timer_preset_writer
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_MINS        = 9,
    parameter int DEFAULT_MINS    = 1,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    input  logic         key_inc_n,
    input  logic         key_dec_n,
    input  logic         key_next_n,
    input  logic         key_go_n,
    timer_load_if.master load,
    output logic [1:0]   edit_sel
);

    localparam logic [3:0] MINS_MAX  = 4'(MAX_MINS);
    localparam logic [3:0] MINS_INIT = 4'(DEFAULT_MINS);

    // Key index order: 0=inc 1=dec 2=next 3=go.
    logic [3:0] raw_n, level, press;
    assign raw_n = {key_go_n, key_next_n, key_dec_n, key_inc_n};

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .CLOCK_50 (CLOCK_50),
            .resetn   (resetn),
            .raw_n    (raw_n[i]),
            .level    (level[i]),
            .press    (press[i])
        );
    end

    state_e     state_q, state_d;
    logic [3:0] mins_q, mins_d, tens_q, tens_d, ones_q, ones_d;
    logic [1:0] rep_pulse;

`ifdef PRESET_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [1:0][RW-1:0] rep_cnt;

    // Held inc/dec re-fires every REPEAT_CYCLES, measured from the debounced press.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rep_cnt   <= '0;
            rep_pulse <= '0;
        end else begin
            rep_pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                if (level[i] || state_q == S_COMMIT) begin
                    rep_cnt[i] <= '0;
                end else if (rep_cnt[i] == REP_LAST) begin
                    rep_cnt[i]   <= '0;
                    rep_pulse[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign rep_pulse = '0;
`endif

    // Only the press pulses matter; the held levels are consumed by auto-repeat when built.
    logic level_unused;
    assign level_unused = ^level;

    logic inc_p, dec_p, next_p, go_p, preset_nonzero;
    assign inc_p          = press[0] | rep_pulse[0];
    assign dec_p          = press[1] | rep_pulse[1];
    assign next_p         = press[2];
    assign go_p           = press[3];
    assign preset_nonzero = |{mins_q, tens_q, ones_q};

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_MIN;
            mins_q  <= MINS_INIT;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            mins_q  <= mins_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    // NOTE: every combinational output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        mins_d  = mins_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        if (state_q == S_COMMIT) begin
            if (load.load_ready) state_d = S_MIN;
        end else if (go_p) begin
            // A zero preset would be a zero-length countdown; stay in editing instead.
            if (preset_nonzero) state_d = S_COMMIT;
        end else begin
            if (inc_p ^ dec_p) begin
                case (state_q)
                    S_MIN:   mins_d = inc_p ? digit_inc(mins_q, MINS_MAX) : digit_dec(mins_q, MINS_MAX);
                    S_TENS:  tens_d = inc_p ? digit_inc(tens_q, TENS_MAX) : digit_dec(tens_q, TENS_MAX);
                    default: ones_d = inc_p ? digit_inc(ones_q, ONES_MAX) : digit_dec(ones_q, ONES_MAX);
                endcase
            end
            if (next_p) state_d = next_edit(state_q);
        end
    end

    assign load.load_valid = (state_q == S_COMMIT);
    assign load.load_mins  = mins_q;
    assign load.load_tens  = tens_q;
    assign load.load_ones  = ones_q;
    assign edit_sel        = state_q;

endmodule
